sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
- Initiator-side controller that drives the SRAM_wrapper port set (CS, OE, WEB[3:0], A, DI, DO) on behalf of a pipeline load/store or fetch client.
- Accepts byte-addressed, sized read/write requests over a valid/ready handshake. Generates word address, byte-lane write enables and replicated write data.
- Captures DO one cycle after the read edge, then aligns and sign/zero-extends it.
- Returns a single response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 14, SRAM word-address width (A port); byte address is ADDR_W+2 bits.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  read zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_W+2  byte address.
- req_wdata  input  32  write data, right-justified.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  client accepts response.
- rsp_rdata  output  32  aligned/extended read data; 0 for writes and errors.
- rsp_err  output  1  misaligned or reserved-size request.
- CS  output  1  SRAM chip select.
- OE  output  1  SRAM output enable.
- WEB  output  4  SRAM byte write enables, active low.
- A  output  ADDR_W  SRAM word address = latched req_addr[ADDR_W+1:2].
- DI  output  32  SRAM write data.
- DO  input  32  SRAM read data; valid in the cycle after the read edge.

Behaviour:
- FSM states: IDLE, WR, RD, RD_DATA, RSP.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, CS=0, OE=0, WEB=4'hF, A=0, DI=0.
- RST forces these values in any state, including mid-transaction.
- CS and OE are combinationally gated by !RST, so no SRAM access occurs in a cycle with RST high.
- IDLE: req_ready=1.
  - On req_valid: latch we/size/unsigned/addr/wdata.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RSP with rsp_err=1. No SRAM access.
  - Otherwise -> WR if we, else RD.
- req_ready=0 in every state except IDLE.
- WR (1 cycle): CS=1, OE=0, A=word addr. Then -> RSP with rsp_rdata=0, rsp_err=0.
  - byte: WEB=~(4'b0001<<addr[1:0]), DI={4{wdata[7:0]}}.
  - half: WEB = addr[1] ? 4'b0011 : 4'b1100, DI={2{wdata[15:0]}}.
  - word: WEB=4'b0000, DI=wdata.
- RD (1 cycle): CS=1, OE=1, WEB=4'hF, A=word addr. Then -> RD_DATA.
- RD_DATA (1 cycle): CS=1, OE=1, WEB=4'hF, A held.
  - Register rsp_rdata from DO: shifted = DO >> (8*addr[1:0]).
  - byte: low 8 bits of shifted, extended by req_unsigned. half: low 16 bits, extended likewise. word: DO.
  - Then -> RSP.
- RSP: rsp_valid=1. CS=0, OE=0, WEB=4'hF.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready, then -> IDLE.
  - rsp_valid deasserts in the cycle after the handshake.
- Latency, request handshake edge to rsp_valid high, with rsp_ready=1:
  - read: 3 cycles.
  - write: 2 cycles.
  - error: 1 cycle.
- Throughput: one request in flight. Next request is accepted the cycle after the response handshake.
- Outside WR, DI holds its last value and WEB=4'hF. A holds the last latched address.
- No combinational path from req_* to SRAM outputs; SRAM outputs decode from registered state/latched fields only (except the RST gate).
- Address wrap: none. Full ADDR_W word space is addressable; top byte address maps to A=all-ones.

Test Plan:
- Reset check: assert RST 2 cycles, any inputs -> req_ready=1, rsp_valid=0, CS=0, OE=0, WEB=4'hF. Then word read of addr 0x0 -> rsp_valid exactly 3 cycles after acceptance.
- Word write/read: write 0xDEADBEEF to 0x0010 -> WR cycle shows CS=1, OE=0, A=4, WEB=4'b0000, DI=0xDEADBEEF. Read 0x0010 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store/load: store 0x000000A5 size byte to 0x0013 -> WEB=4'b0111, DI=0xA5A5A5A5. Signed byte read of 0x0013 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Halfword alignment: after word write 0x8001_7FFE to 0x0020:
  - signed half read at 0x0022 -> 0xFFFF8001.
  - unsigned half read at 0x0022 -> 0x00008001.
  - signed half read at 0x0020 -> 0x00007FFE.
  - half write 0x1234 to 0x0022 -> WEB=4'b0011, DI=0x12341234.
- Errors: word read at 0x0011, half write at 0x0021, size 11 -> rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after acceptance, CS never asserted.
- Backpressure and reset abort:
  - hold rsp_ready=0 for 4 cycles on a read response -> rsp_valid, rsp_rdata stable, req_ready=0, CS=0.
  - assert RST during RD -> CS=0 that cycle, IDLE next, no response emitted.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Initiator-side SRAM access controller: turns sized byte-addressed requests into
// SRAM_wrapper cycles (CS/OE/WEB/A/DI) and returns one aligned response per request.
module sram_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              CS,
    output logic              OE,
    output logic [3:0]        WEB,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // IDLE accept | WR write strobe | RD read edge | RD_DATA capture DO | RSP hold response
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       di_q, di_d;

    logic              req_err;
    logic [3:0]        web_wr;
    logic [31:0]       di_wr;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_aligned;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Write lane decode works only from latched fields so req_* never reaches the SRAM pins.
    always_comb begin
        web_wr = 4'hF;
        di_wr  = di_q;
        unique case (size_q)
            SZ_BYTE: begin
                web_wr = ~(4'b0001 << addr_q[1:0]);
                di_wr  = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                web_wr = addr_q[1] ? 4'b0011 : 4'b1100;
                di_wr  = {2{wdata_q[15:0]}};
            end
            SZ_WORD: begin
                web_wr = 4'b0000;
                di_wr  = wdata_q;
            end
            default: begin
                web_wr = 4'hF;
                di_wr  = di_q;
            end
        endcase
    end

    always_comb begin
        rd_byte    = DO[{addr_q[1:0], 3'b000} +: 8];
        rd_half    = addr_q[1] ? DO[31:16] : DO[15:0];
        rd_aligned = DO;
        unique case (size_q)
            SZ_BYTE: rd_aligned = uns_q ? {24'h000000, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_aligned = uns_q ? {16'h0000, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
            default: rd_aligned = DO;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        di_d    = di_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RSP;
                    end else if (req_we) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                di_d    = di_wr;
                state_d = RSP;
            end
            RD: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                rdata_d = rd_aligned;
                state_d = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            di_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            di_q    <= di_d;
        end
    end

    logic sram_active;
    logic sram_read;

    assign sram_active = (state_q == WR) || (state_q == RD) || (state_q == RD_DATA);
    assign sram_read   = (state_q == RD) || (state_q == RD_DATA);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // RST gates the strobes directly so a reset cycle can never touch the array.
    assign CS  = sram_active && !RST;
    assign OE  = sram_read && !RST;
    assign WEB = (state_q == WR) ? web_wr : 4'hF;
    assign A   = addr_q[ADDR_W+1:2];
    assign DI  = (state_q == WR) ? di_wr : di_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a small behavioural SRAM; expected values
// are hand-computed constants.
module tb_sram_access_ctrl;
    localparam int ADDR_W = 14;

    logic              CK = 1'b0;
    logic              RST = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              CS;
    logic              OE;
    logic [3:0]        WEB;
    logic [ADDR_W-1:0] A;
    logic [31:0]       DI;
    logic [31:0]       DO = 32'h0;

    sram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CK(CK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 CK = ~CK;

    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    always @(posedge CK) begin
        if (CS) begin
            for (int l = 0; l < 4; l++)
                if (!WEB[l]) mem[A[7:0]][8*l +: 8] <= DI[8*l +: 8];
            if (OE) DO <= mem[A[7:0]];
        end
    end

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    int          lat;
    logic [31:0] r_data;
    logic        r_err;
    logic        wr_cs, wr_oe, cs_seen;
    logic [3:0]  wr_web;
    logic [ADDR_W-1:0] wr_a;
    logic [31:0] wr_di;

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [15:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        lat = 1;
        cs_seen = CS;
        wr_cs = CS; wr_oe = OE; wr_web = WEB; wr_a = A; wr_di = DI;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
            cs_seen = cs_seen | CS;
        end
        r_data = rsp_rdata;
        r_err  = rsp_err;
        step();
    endtask

    logic [31:0] held;
    logic        ok;

    initial begin
        // Reset with a live request on the inputs
        RST = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 16'h0010; req_wdata = 32'hFFFF_FFFF;
        step(); step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cs", CS, 0);
        chk("rst_oe", OE, 0);
        chk("rst_web", WEB, 4'hF);
        chk("rst_a", A, 0);
        chk("rst_di", DI, 0);
        chk("rst_rdata", rsp_rdata, 0);
        RST = 1'b0; req_valid = 1'b0;

        xact(0, 2'b10, 0, 16'h0000, 0);
        chk("rd0_lat", lat, 3);
        chk("rd0_data", r_data, 32'h0);
        chk("rd0_err", r_err, 0);

        xact(1, 2'b10, 0, 16'h0010, 32'hDEAD_BEEF);
        chk("ww_lat", lat, 2);
        chk("ww_cs", wr_cs, 1);
        chk("ww_oe", wr_oe, 0);
        chk("ww_a", wr_a, 4);
        chk("ww_web", wr_web, 4'b0000);
        chk("ww_di", wr_di, 32'hDEAD_BEEF);
        chk("ww_rdata", r_data, 0);
        chk("ww_err", r_err, 0);
        chk("idle_web", WEB, 4'hF);
        chk("idle_di_hold", DI, 32'hDEAD_BEEF);

        xact(0, 2'b10, 0, 16'h0010, 0);
        chk("rw_data", r_data, 32'hDEAD_BEEF);
        chk("rw_err", r_err, 0);

        xact(1, 2'b00, 0, 16'h0013, 32'h0000_00A5);
        chk("wb_web", wr_web, 4'b0111);
        chk("wb_di", wr_di, 32'hA5A5_A5A5);
        xact(0, 2'b00, 0, 16'h0013, 0);
        chk("rb_signed", r_data, 32'hFFFF_FFA5);
        xact(0, 2'b00, 1, 16'h0013, 0);
        chk("rb_unsigned", r_data, 32'h0000_00A5);
        xact(0, 2'b00, 0, 16'h0011, 0);
        chk("rb_lane1", r_data, 32'hFFFF_FFBE);
        xact(0, 2'b10, 0, 16'h0010, 0);
        chk("rw_after_byte", r_data, 32'hA5AD_BEEF);

        xact(1, 2'b10, 0, 16'h0020, 32'h8001_7FFE);
        xact(0, 2'b01, 0, 16'h0022, 0);
        chk("rh_hi_signed", r_data, 32'hFFFF_8001);
        xact(0, 2'b01, 1, 16'h0022, 0);
        chk("rh_hi_unsigned", r_data, 32'h0000_8001);
        xact(0, 2'b01, 0, 16'h0020, 0);
        chk("rh_lo_signed", r_data, 32'h0000_7FFE);
        xact(1, 2'b01, 0, 16'h0022, 32'h0000_1234);
        chk("wh_web", wr_web, 4'b0011);
        chk("wh_di", wr_di, 32'h1234_1234);
        chk("wh_a", wr_a, 8);
        xact(0, 2'b10, 0, 16'h0020, 0);
        chk("rw_after_half", r_data, 32'h1234_7FFE);

        // Errors: rdata must be cleared even though the previous read left data behind
        xact(0, 2'b10, 0, 16'h0011, 0);
        chk("e_word_err", r_err, 1);
        chk("e_word_data", r_data, 0);
        chk("e_word_lat", lat, 1);
        chk("e_word_cs", cs_seen, 0);
        xact(1, 2'b01, 0, 16'h0021, 32'hFFFF_FFFF);
        chk("e_half_err", r_err, 1);
        chk("e_half_lat", lat, 1);
        chk("e_half_cs", cs_seen, 0);
        xact(0, 2'b11, 0, 16'h0000, 0);
        chk("e_size_err", r_err, 1);
        chk("e_size_data", r_data, 0);
        chk("e_size_lat", lat, 1);
        chk("e_size_cs", cs_seen, 0);

        // Top of the address space
        xact(1, 2'b00, 0, 16'hFFFF, 32'h0000_005A);
        chk("top_a", wr_a, 14'h3FFF);
        chk("top_web", wr_web, 4'b0111);
        xact(0, 2'b00, 0, 16'hFFFF, 0);
        chk("top_rd", r_data, 32'h0000_005A);

        // Backpressure on a read response
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 16'h0010;
        step();
        req_valid = 1'b0;
        step(); step();
        chk("bp_valid", rsp_valid, 1);
        chk("bp_data", rsp_rdata, 32'hA5AD_BEEF);
        held = rsp_rdata;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!(rsp_valid === 1'b1 && rsp_rdata === held && req_ready === 1'b0 && CS === 1'b0))
                ok = 1'b0;
        end
        chk("bp_stable", ok, 1);
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // Reset aborting a read
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0020;
        step();
        req_valid = 1'b0;
        chk("ab_cs_rd", CS, 1);
        RST = 1'b1;
        #1;
        chk("ab_cs_gated", CS, 0);
        chk("ab_oe_gated", OE, 0);
        step();
        RST = 1'b0;
        chk("ab_idle_ready", req_ready, 1);
        chk("ab_no_rsp", rsp_valid, 0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid !== 1'b0 || CS !== 1'b0) ok = 1'b0;
        end
        chk("ab_quiet", ok, 1);
        xact(0, 2'b10, 0, 16'h0020, 0);
        chk("ab_recover", r_data, 32'h1234_7FFE);
        chk("ab_recover_lat", lat, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
